// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares the single-port SRAM between VGA, UART, M2 and M1 clients.
// VGA has absolute priority and may preempt a locked owner. Clients 1..3 are served
// round-robin. Every owner change passes through a one-cycle dead state with writes
// disabled. Each read is tagged with its owner, so rdata_valid names the right client
// READ_LATENCY cycles later.
module sram_access_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int MAX_HOLD     = 64,
    parameter int NUM_REQ      = 4
) (
    input  logic                    CLOCK_50_I,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      lock,
    input  logic [18*NUM_REQ-1:0]   cli_addr,
    input  logic [NUM_REQ-1:0]      cli_we_n,
    input  logic [16*NUM_REQ-1:0]   cli_wdata,
    output logic [NUM_REQ-1:0]      grant,
    output logic [17:0]             SRAM_address,
    output logic [15:0]             SRAM_write_data,
    output logic                    SRAM_we_n,
    input  logic [15:0]             SRAM_read_data,
    output logic [15:0]             rdata,
    output logic [NUM_REQ-1:0]      rdata_valid,
    output logic                    busy
);

    localparam int HW = $clog2(MAX_HOLD) + 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SWITCH} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [1:0]           rr_q, rr_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [17:0]          addr_q;
    logic [15:0]          wdata_q;
    logic [2:0]           tag_q [READ_LATENCY];

    logic [1:0]           own, win, rr_nxt;
    logic                 granted, any_req, pend, keep, preempt, starve;

    // VGA wins outright; otherwise scan clients 1..3 starting at the rr pointer.
    function automatic logic [1:0] pick(input logic [NUM_REQ-1:0] r, input logic [1:0] p);
        logic [1:0] w;
        int c;
        w = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            c = int'(p) + k;
            if (c > 3) c = c - 3;
            if (r[c[1:0]]) w = c[1:0];
        end
        return r[0] ? 2'd0 : w;
    endfunction

    assign own     = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]};
    assign granted = (state_q == S_GRANT);
    assign win     = pick(req, rr_q);
    assign rr_nxt  = (win == 2'd3) ? 2'd1 : win + 2'd1;
    assign any_req = |req;
    assign pend    = |(req & ~grant_q);
    assign keep    = req[own] & lock[own];
    assign preempt = req[0] & (own != 2'd0);
    assign starve  = pend & (hold_q == HW'(MAX_HOLD - 1));

    assign SRAM_address    = granted ? cli_addr[18*own +: 18] : addr_q;
    assign SRAM_write_data = granted ? cli_wdata[16*own +: 16] : wdata_q;
    assign SRAM_we_n       = granted ? cli_we_n[own] : 1'b1;
    assign grant           = grant_q;
    assign busy            = |grant_q;
    assign rdata           = SRAM_read_data;
    assign rdata_valid     = tag_q[READ_LATENCY-1][2] ? (NUM_REQ'(1) << tag_q[READ_LATENCY-1][1:0]) : '0;

    // Next-state arbitration: grant from idle/switch, release or preempt/starve from grant.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        if (granted) begin
            if (preempt || !keep || starve) begin
                state_d = pend ? S_SWITCH : S_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end else if (pend) begin
                hold_d = hold_q + 1'b1;
            end
        end else begin
            hold_d  = '0;
            state_d = any_req ? S_GRANT : S_IDLE;
            grant_d = any_req ? (NUM_REQ'(1) << win) : '0;
            rr_d    = (any_req && win != 2'd0) ? rr_nxt : rr_q;
        end
    end

    // Arbiter state, owner, round-robin pointer and hold counter registers.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= 2'd1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
        end
    end

    // Last bus values are held so an idle bus never changes address or data.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= SRAM_address;
            wdata_q <= SRAM_write_data;
        end
    end

    // Read tag pipeline: {is_read, owner} travels alongside the SRAM read latency.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= {granted & SRAM_we_n, own};
            for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed scenarios for the SRAM access arbiter.
module tb_sram_access_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req, lock, cli_we_n, grant, rdata_valid;
    logic [71:0] cli_addr;
    logic [63:0] cli_wdata;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data, SRAM_read_data, rdata;
    logic        SRAM_we_n, busy;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #10 clk = ~clk;

    sram_access_arbiter dut (
        .CLOCK_50_I      (clk),
        .resetn          (resetn),
        .req             (req),
        .lock            (lock),
        .cli_addr        (cli_addr),
        .cli_we_n        (cli_we_n),
        .cli_wdata       (cli_wdata),
        .grant           (grant),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .rdata           (rdata),
        .rdata_valid     (rdata_valid),
        .busy            (busy)
    );

    task automatic do_reset;
        resetn = 1'b1;
        req = '0; lock = '0; cli_addr = '0; cli_we_n = 4'hF; cli_wdata = '0; SRAM_read_data = '0;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #5 resetn = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b1;
        req = '0; lock = '0; cli_addr = '0; cli_we_n = 4'hF; cli_wdata = '0; SRAM_read_data = '0;
        #1 resetn = 1'b0;
        #1;
        tests_run++;
        if ({grant, busy, SRAM_we_n, rdata_valid} !== {4'b0, 1'b0, 1'b1, 4'b0}) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got grant=%b busy=%b we_n=%b rv=%b, expected 0000 0 1 0000", grant, busy, SRAM_we_n, rdata_valid);
        end
        tests_run++;
        if ({SRAM_address, SRAM_write_data} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr=%0d wd=%h, expected 0 0000", SRAM_address, SRAM_write_data);
        end
        repeat (2) @(posedge clk);
        #5 resetn = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({grant, SRAM_we_n} !== {4'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got grant=%b we_n=%b, expected 0000 1", grant, SRAM_we_n);
        end
    endtask

    task automatic test_uart_locked_writes;
        do_reset();
        @(posedge clk); #1;
        req = 4'b0010; lock = 4'b0010; cli_we_n = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cli_addr[35:18] = 18'(100 + i);
            cli_wdata[31:16] = 16'hA000 + 16'(i);
            if (i == 4) req = '0;
            #1;
            tests_run++;
            if ({grant, SRAM_we_n, SRAM_address, SRAM_write_data} !== {4'b0010, 1'b0, 18'(100 + i), 16'hA000 + 16'(i)}) begin
                tests_failed++;
                $display("FAIL uart_write[%0d]: got grant=%b we_n=%b addr=%0d wd=%h, expected 0010 0 %0d %h",
                         i, grant, SRAM_we_n, SRAM_address, SRAM_write_data, 100 + i, 16'hA000 + 16'(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({grant, SRAM_we_n, busy, SRAM_address} !== {4'b0, 1'b1, 1'b0, 18'd104}) begin
                tests_failed++;
                $display("FAIL uart_after_burst[%0d]: got grant=%b we_n=%b busy=%b addr=%0d, expected 0000 1 0 104",
                         i, grant, SRAM_we_n, busy, SRAM_address);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_g [8];
        logic [17:0] exp_a [8];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        exp_a = '{18'd500, 18'd0, 18'd1000, 18'd0, 18'd2000, 18'd0, 18'd3000, 18'd0};
        do_reset();
        @(posedge clk); #1;
        req = 4'hF; lock = '0; cli_we_n = 4'hF;
        cli_addr = {18'd3000, 18'd2000, 18'd1000, 18'd500};
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({grant, SRAM_we_n} !== {exp_g[c], 1'b1}) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got grant=%b we_n=%b, expected %b 1", c + 1, grant, SRAM_we_n, exp_g[c]);
            end
            if (exp_g[c] != 4'b0) begin
                tests_run++;
                if (SRAM_address !== exp_a[c]) begin
                    tests_failed++;
                    $display("FAIL rr_addr[%0d]: got %0d, expected %0d", c + 1, SRAM_address, exp_a[c]);
                end
            end
            req = req & ~exp_g[c];
        end
    endtask

    task automatic test_vga_preempt;
        logic [3:0] eg, ev;
        do_reset();
        SRAM_read_data = 16'h5A5A;
        @(posedge clk); #1;
        req = 4'b0100; lock = 4'b0100; cli_we_n = 4'hF; cli_addr[53:36] = 18'd777;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 10) req[0] = 1'b1;
            #1;
            eg = (c <= 10) ? 4'b0100 : (c == 11 || c == 13) ? 4'b0000 : 4'b0001;
            ev = (c < 3) ? 4'b0000 : (c <= 12) ? 4'b0100 : (c == 13) ? 4'b0000 : 4'b0001;
            tests_run++;
            if ({grant, rdata_valid} !== {eg, ev}) begin
                tests_failed++;
                $display("FAIL preempt[%0d]: got grant=%b rv=%b, expected %b %b", c, grant, rdata_valid, eg, ev);
            end
            if (c == 11) begin
                tests_run++;
                if (SRAM_we_n !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL preempt_switch_we_n: got %b, expected 1", SRAM_we_n);
                end
            end
        end
        tests_run++;
        if (rdata !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL preempt_rdata: got %h, expected 5a5a", rdata);
        end
        req = '0;
    endtask

    task automatic test_vga_read;
        do_reset();
        SRAM_read_data = 16'hBEEF;
        @(posedge clk); #1;
        req = 4'b0001; cli_we_n = 4'hF; cli_addr[17:0] = 18'd146944;
        @(posedge clk); #1;
        req = '0;
        #1;
        tests_run++;
        if ({grant, SRAM_address, SRAM_we_n, rdata_valid} !== {4'b0001, 18'd146944, 1'b1, 4'b0}) begin
            tests_failed++;
            $display("FAIL vga_read_issue: got grant=%b addr=%0d we_n=%b rv=%b, expected 0001 146944 1 0000",
                     grant, SRAM_address, SRAM_we_n, rdata_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({grant, rdata_valid, SRAM_address} !== {4'b0, 4'b0, 18'd146944}) begin
            tests_failed++;
            $display("FAIL vga_read_wait: got grant=%b rv=%b addr=%0d, expected 0000 0000 146944", grant, rdata_valid, SRAM_address);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({rdata_valid, rdata} !== {4'b0001, 16'hBEEF}) begin
            tests_failed++;
            $display("FAIL vga_read_data: got rv=%b rdata=%h, expected 0001 beef", rdata_valid, rdata);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rdata_valid !== 4'b0) begin
            tests_failed++;
            $display("FAIL vga_read_done: got rv=%b, expected 0000", rdata_valid);
        end
    endtask

    task automatic test_starvation;
        do_reset();
        @(posedge clk); #1;
        req = 4'b1000; lock = 4'b1000; cli_we_n = 4'hF;
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk); #1;
            if (c == 1) req = 4'b1010;
            tests_run++;
            if (grant !== ((c <= 64) ? 4'b1000 : (c == 65) ? 4'b0000 : 4'b0010)) begin
                tests_failed++;
                $display("FAIL starve[%0d]: got grant=%b, expected %b", c, grant,
                         (c <= 64) ? 4'b1000 : (c == 65) ? 4'b0000 : 4'b0010);
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        @(posedge clk); #1;
        req = 4'b1000; lock = 4'b1000; cli_we_n = 4'b0111;
        cli_addr[71:54] = 18'd5000; cli_wdata[63:48] = 16'h1234;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({grant, SRAM_we_n, SRAM_address} !== {4'b1000, 1'b0, 18'd5000}) begin
                tests_failed++;
                $display("FAIL burst_write[%0d]: got grant=%b we_n=%b addr=%0d, expected 1000 0 5000", c, grant, SRAM_we_n, SRAM_address);
            end
        end
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({grant, SRAM_we_n, busy, SRAM_address, SRAM_write_data, rdata_valid} !== {4'b0, 1'b1, 1'b0, 18'd0, 16'd0, 4'b0}) begin
            tests_failed++;
            $display("FAIL async_reset: got grant=%b we_n=%b busy=%b addr=%0d wd=%h rv=%b, expected 0000 1 0 0 0000 0000",
                     grant, SRAM_we_n, busy, SRAM_address, SRAM_write_data, rdata_valid);
        end
        req = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            if (c == 2) #5 resetn = 1'b1;
            #1;
            tests_run++;
            if ({grant, SRAM_we_n} !== {4'b0, 1'b1}) begin
                tests_failed++;
                $display("FAIL after_reset[%0d]: got grant=%b we_n=%b, expected 0000 1", c, grant, SRAM_we_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_uart_locked_writes();
        test_round_robin();
        test_vga_preempt();
        test_vga_read();
        test_starvation();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
